tea_encryptor_iterative: RTL
============================

// Module: tea_encryptor_iterative
// PURPOSE
//  Sequential TEA encryptor, the transmit-side counterpart of the decryption round datapath.
//  Accepts one 64-bit plaintext block and a 128-bit key over a valid/ready handshake.
//  Runs ROUNDS TEA encryption rounds iteratively on two functionF instances.
//  Presents the 64-bit ciphertext over a valid/ready handshake.
// PARAMETERS
//  ROUNDS  32            number of Feistel cycles; must be >=2 and even
//  DELTA   32'h9E3779B9  key-schedule constant added to sum every round
// PORTS
//  clk        in   1    single clock; all state updates on rising edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    plaintext/key present
//  in_ready   out  1    block can accept; = (state==IDLE)
//  key        in   128  k[0]=key[31:0], k[1]=key[63:32], k[2]=key[95:64], k[3]=key[127:96]
//  in_v0      in   32   plaintext, least significant word
//  in_v1      in   32   plaintext, most significant word
//  out_valid  out  1    ciphertext valid; = (state==DONE)
//  out_ready  in   1    consumer accepts ciphertext
//  out_v0     out  32   ciphertext, least significant word
//  out_v1     out  32   ciphertext, most significant word
// BEHAVIOUR
//  - Reset: state=IDLE, v0/v1/sum/round_cnt/key_q=0.
//    out_v0/out_v1=0, out_valid=0, in_ready=1 from the first post-reset cycle.
//  - FSM states IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: on in_valid&in_ready, latch in_v0/in_v1/key into v0/v1/key_q, sum=0, round_cnt=0, go to RUN.
//    Key and plaintext inputs are don't-care after the accept edge.
//  - RUN, one round per edge, all arithmetic modulo 2^32:
//      s' = sum + DELTA
//      v0' = v0 + F(v1, k0, k1, s')
//      v1' = v1 + F(v0', k2, k3, s')
//      F(x, a, b, s) = ((x<<4)+a) ^ (x+s) ^ ((x>>5)+b), logical shift
//  - RUN bookkeeping: round_cnt increments each round. The edge that completes round ROUNDS moves to DONE.
//  - Latency: out_valid rises exactly ROUNDS+1 edges after the accept edge. in_ready=0 throughout RUN and DONE.
//  - DONE: out_v0/out_v1 hold the final v0/v1 stable while out_valid=1.
//    On out_valid&out_ready, go to IDLE. No new accept in that same cycle.
//    Minimum block-to-block period: ROUNDS+2 cycles.
//  - out_v0/out_v1 are driven from the v0/v1 registers at all times; they are meaningful only while out_valid=1.
//  - in_valid while busy is ignored; no queueing and no error flag.
//  - out_ready while not DONE is ignored.
//  - rst during RUN or DONE aborts immediately: back to the reset state next cycle, the pending result is discarded.
//  - The final sum equals DELTA*ROUNDS mod 2^32 (0xC6EF3720 for 32 rounds). This is the starting sum the decryptor needs.
// CONFIGURATION
//  TEA_ENC_UNROLL2_EN
//  - Defined: two chained rounds per RUN edge, using a second functionF pair.
//    sum advances by 2*DELTA per edge; the first round uses sum+DELTA, the second sum+2*DELTA.
//    round_cnt counts edges up to ROUNDS/2. out_valid rises ROUNDS/2+1 edges after accept.
//  - Undefined: one round per edge, as above.
//  - Ciphertext is bit-identical in both builds.
// TESTING
//  1. key=0, in_v1:in_v0=0:0, ROUNDS=32 -> out_v0=32'h41EA3A0A, out_v1=32'h94BAA940.
//     out_valid exactly 33 edges after accept (17 with UNROLL2).
//  2. Random key/plaintext x1000 -> ciphertext matches a C TEA reference model.
//     Feeding the ciphertext through 32 decryption rounds (sum from 0xC6EF3720 down by DELTA) recovers the plaintext.
//  3. Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_v0/out_v1 stable, in_ready=0.
//     Raise out_ready -> IDLE next edge, in_ready=1.
//  4. Pulse in_valid with new data during RUN, and change key mid-RUN -> ignored; result equals the originally accepted block.
//  5. Assert rst at round 10 -> next cycle: state IDLE, out_valid=0, out_v0/out_v1=0, in_ready=1.
//     A following block encrypts correctly.
//  6. in_valid held high with out_ready=1 across 3 blocks -> 3 correct results.
//     Period is 34 cycles per block (18 with UNROLL2).

Source files
------------

// File: rtl/tea_encryptor_iterative.sv
// Iterative TEA encryptor: one Feistel cycle per clock, valid/ready in and out.
// Optional macro TEA_ENC_UNROLL2_EN chains two cycles per clock for half the latency.
module tea_encryptor_iterative #(
    parameter int          ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [31:0]  in_v0,
    input  logic [31:0]  in_v1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_v0,
    output logic [31:0]  out_v1
);

`ifdef TEA_ENC_UNROLL2_EN
    localparam int LAST_EDGE = ROUNDS / 2;
`else
    localparam int LAST_EDGE = ROUNDS;
`endif
    localparam int CNT_W = $clog2(LAST_EDGE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_v0;
    logic [31:0]        r_v1;
    logic [31:0]        r_sum;
    logic [CNT_W-1:0]   r_round_cnt;
    logic [127:0]       r_key_q;

    logic [31:0] w_k0, w_k1, w_k2, w_k3;
    logic [31:0] w_s1, w_v0_a, w_v1_a;
    logic [31:0] w_next_v0, w_next_v1, w_next_sum;

    function automatic logic [31:0] function_f(
        input logic [31:0] x,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] s
    );
        return ((x << 4) + a) ^ (x + s) ^ ((x >> 5) + b);
    endfunction

    assign w_k0 = r_key_q[31:0];
    assign w_k1 = r_key_q[63:32];
    assign w_k2 = r_key_q[95:64];
    assign w_k3 = r_key_q[127:96];

    // First round of the edge; v1 uses the freshly updated v0.
    assign w_s1   = r_sum + DELTA;
    assign w_v0_a = r_v0 + function_f(r_v1, w_k0, w_k1, w_s1);
    assign w_v1_a = r_v1 + function_f(w_v0_a, w_k2, w_k3, w_s1);

`ifdef TEA_ENC_UNROLL2_EN
    logic [31:0] w_s2, w_v0_b, w_v1_b;

    assign w_s2   = w_s1 + DELTA;
    assign w_v0_b = w_v0_a + function_f(w_v1_a, w_k0, w_k1, w_s2);
    assign w_v1_b = w_v1_a + function_f(w_v0_b, w_k2, w_k3, w_s2);

    assign w_next_v0  = w_v0_b;
    assign w_next_v1  = w_v1_b;
    assign w_next_sum = w_s2;
`else
    assign w_next_v0  = w_v0_a;
    assign w_next_v1  = w_v1_a;
    assign w_next_sum = w_s1;
`endif

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_v0        <= '0;
            r_v1        <= '0;
            r_sum       <= '0;
            r_round_cnt <= '0;
            r_key_q     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_v0        <= in_v0;
                        r_v1        <= in_v1;
                        r_key_q     <= key;
                        r_sum       <= '0;
                        r_round_cnt <= '0;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    r_v0        <= w_next_v0;
                    r_v1        <= w_next_v1;
                    r_sum       <= w_next_sum;
                    r_round_cnt <= r_round_cnt + 1'b1;
                    if (r_round_cnt == CNT_W'(LAST_EDGE - 1))
                        r_state <= DONE;
                end
                DONE: begin
                    // Returning to IDLE here means no accept can share this edge.
                    if (out_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_v0    = r_v0;
    assign out_v1    = r_v1;

endmodule
